// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: NUM_LAYERS fixed-priority sprite layers over a background,
// with frame-synchronous config double-buffering and a per-frame collision mask.
module sprite_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4,
  parameter logic [3*COLOR_W-1:0] KEY_COLOR = '0,
  parameter int COORD_W    = 10
) (
  input  logic                          VGA_Clk,
  input  logic                          Reset_h,
  input  logic [COORD_W-1:0]            DrawX,
  input  logic [COORD_W-1:0]            DrawY,
  input  logic                          blank,
  input  logic                          frame_start,
  input  logic                          cfg_we,
  input  logic [2:0]                    cfg_layer,
  input  logic [COORD_W-1:0]            cfg_x,
  input  logic [COORD_W-1:0]            cfg_y,
  input  logic [COORD_W-1:0]            cfg_size,
  input  logic                          cfg_en,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [3*COLOR_W-1:0]          bkg_rgb,
  output logic [7:0]                    Red,
  output logic [7:0]                    Green,
  output logic [7:0]                    Blue,
  output logic                          hit_valid,
  output logic [2:0]                    hit_layer,
  output logic [NUM_LAYERS-1:0]         collide_mask
);

  localparam int PIX_W = 3*COLOR_W;
  localparam int unsigned CW = COLOR_W;

  logic [COORD_W-1:0] sh_x [NUM_LAYERS];
  logic [COORD_W-1:0] sh_y [NUM_LAYERS];
  logic [COORD_W-1:0] sh_size [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] sh_en;
  logic [COORD_W-1:0] ac_x [NUM_LAYERS];
  logic [COORD_W-1:0] ac_y [NUM_LAYERS];
  logic [COORD_W-1:0] ac_size [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] ac_en;

  logic [NUM_LAYERS-1:0] in_c, in_s1, opaque;
  logic                  blank_s1;
  logic                  found, multi;
  logic [2:0]            win;
  logic [PIX_W-1:0]      sel_rgb;
  logic [COORD_W-1:0]    dx, dy;

  function automatic logic [7:0] widen(input logic [COLOR_W-1:0] c);
    logic [7:0] w;
    w = '0;
    // Cycling through c from its MSB yields {c, c[MSB -: 8-COLOR_W]} for any COLOR_W in 4..8.
    for (int unsigned b = 0; b < 8; b++)
      w[7-b] = c[CW-1-(b % CW)];
    return w;
  endfunction

  // Shadow writes and the frame-start copy share one block so the copy sees the pre-write shadow.
  always_ff @(posedge VGA_Clk) begin
    if (Reset_h) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        sh_x[i] <= '0; sh_y[i] <= '0; sh_size[i] <= '0;
        ac_x[i] <= '0; ac_y[i] <= '0; ac_size[i] <= '0;
      end
      sh_en <= '0;
      ac_en <= '0;
    end else begin
      if (frame_start) begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
          ac_x[i] <= sh_x[i]; ac_y[i] <= sh_y[i]; ac_size[i] <= sh_size[i];
        end
        ac_en <= sh_en;
      end
      if (cfg_we) begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
          if (cfg_layer == 3'(i)) begin
            sh_x[i] <= cfg_x; sh_y[i] <= cfg_y; sh_size[i] <= cfg_size;
            sh_en[i] <= cfg_en;
          end
        end
      end
    end
  end

  always_comb begin
    in_c = '0;
    dx   = '0;
    dy   = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      dx = DrawX - ac_x[i];
      dy = DrawY - ac_y[i];
      in_c[i] = ac_en[i] && (dx < ac_size[i]) && (dy < ac_size[i]);
    end
  end

  always_comb begin
    opaque  = '0;
    found   = 1'b0;
    win     = '0;
    sel_rgb = bkg_rgb;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = in_s1[i] && (layer_rgb[i*PIX_W +: PIX_W] != KEY_COLOR);
      if (opaque[i] && !found) begin
        found   = 1'b1;
        win     = 3'(i);
        sel_rgb = layer_rgb[i*PIX_W +: PIX_W];
      end
    end
    multi = |(opaque & (opaque - 1'b1));
  end

  always_ff @(posedge VGA_Clk) begin
    if (Reset_h) begin
      in_s1        <= '0;
      blank_s1     <= 1'b0;
      Red          <= '0;
      Green        <= '0;
      Blue         <= '0;
      hit_valid    <= 1'b0;
      hit_layer    <= '0;
      collide_mask <= '0;
    end else begin
      in_s1    <= in_c;
      blank_s1 <= blank;
      if (blank_s1) begin
        Red       <= widen(sel_rgb[PIX_W-1 -: COLOR_W]);
        Green     <= widen(sel_rgb[2*COLOR_W-1 -: COLOR_W]);
        Blue      <= widen(sel_rgb[COLOR_W-1:0]);
        hit_valid <= found;
        if (found) hit_layer <= win;
      end else begin
        Red       <= '0;
        Green     <= '0;
        Blue      <= '0;
        hit_valid <= 1'b0;
      end
      if (frame_start)
        collide_mask <= (blank_s1 && multi) ? opaque : '0;
      else if (blank_s1 && multi)
        collide_mask <= collide_mask | opaque;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: each pixel is driven through both stages and
// its t+2 outputs are compared against hand-computed values.
module tb_sprite_compositor;

  logic        VGA_Clk = 1'b0;
  logic        Reset_h;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start, cfg_we, cfg_en;
  logic [2:0]  cfg_layer;
  logic [9:0]  cfg_x, cfg_y, cfg_size;
  logic [47:0] layer_rgb;
  logic [11:0] bkg_rgb;
  logic [7:0]  Red, Green, Blue;
  logic        hit_valid;
  logic [2:0]  hit_layer;
  logic [3:0]  collide_mask;

  int errors = 0;
  int checks = 0;

  sprite_compositor #(.NUM_LAYERS(4), .COLOR_W(4), .KEY_COLOR(12'h000), .COORD_W(10)) dut (
    .VGA_Clk(VGA_Clk), .Reset_h(Reset_h), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_size(cfg_size), .cfg_en(cfg_en), .layer_rgb(layer_rgb),
    .bkg_rgb(bkg_rgb), .Red(Red), .Green(Green), .Blue(Blue), .hit_valid(hit_valid),
    .hit_layer(hit_layer), .collide_mask(collide_mask)
  );

  always #5 VGA_Clk = ~VGA_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_Clk);
    #1;
  endtask

  function automatic logic [47:0] pk(input logic [11:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Coordinates in cycle t, sprite/background pixels in cycle t+1, sample in t+2.
  task automatic pix(input logic [9:0] x, y, input logic bl, input logic [47:0] lrgb,
                     input logic [11:0] bkg);
    DrawX = x; DrawY = y; blank = bl;
    tick();
    layer_rgb = lrgb; bkg_rgb = bkg;
    tick();
  endtask

  task automatic expect_px(input string tag, input logic [7:0] r, g, b,
                           input logic hv, input logic [2:0] hl);
    check({tag, ".R"}, 32'(Red), 32'(r));
    check({tag, ".G"}, 32'(Green), 32'(g));
    check({tag, ".B"}, 32'(Blue), 32'(b));
    check({tag, ".hv"}, 32'(hit_valid), 32'(hv));
    check({tag, ".hl"}, 32'(hit_layer), 32'(hl));
  endtask

  task automatic cfg(input logic [2:0] l, input logic [9:0] x, y, s, input logic en,
                     input logic with_frame);
    blank = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_layer = l; cfg_x = x; cfg_y = y; cfg_size = s; cfg_en = en;
    frame_start = with_frame;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame();
    blank = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    Reset_h = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_layer = '0; cfg_x = '0; cfg_y = '0; cfg_size = '0; cfg_en = 1'b0;
    layer_rgb = '0; bkg_rgb = '0;
    repeat (3) tick();
    expect_px("reset", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    check("reset.mask", 32'(collide_mask), 32'h0);
    Reset_h = 1'b0;

    pix(10'd7, 10'd9, 1'b0, '0, 12'h123);
    expect_px("blanked", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    pix(10'd7, 10'd9, 1'b1, '0, 12'h123);
    expect_px("bkg", 8'h11, 8'h22, 8'h33, 1'b0, 3'd0);

    cfg(3'd1, 10'd100, 10'd50, 10'd32, 1'b1, 1'b0);
    frame();
    pix(10'd100, 10'd50, 1'b1, pk(12'h0, 12'hF00, 12'h0, 12'h0), 12'h123);
    expect_px("l1.tl", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd1);
    pix(10'd131, 10'd81, 1'b1, pk(12'h0, 12'hF00, 12'h0, 12'h0), 12'h123);
    expect_px("l1.br", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd1);
    pix(10'd132, 10'd81, 1'b1, pk(12'h0, 12'hF00, 12'h0, 12'h0), 12'h123);
    expect_px("l1.right", 8'h11, 8'h22, 8'h33, 1'b0, 3'd1);
    pix(10'd99, 10'd50, 1'b1, pk(12'h0, 12'hF00, 12'h0, 12'h0), 12'h123);
    expect_px("l1.left", 8'h11, 8'h22, 8'h33, 1'b0, 3'd1);

    cfg(3'd0, 10'd190, 10'd190, 10'd20, 1'b1, 1'b0);
    cfg(3'd2, 10'd195, 10'd195, 10'd20, 1'b1, 1'b0);
    frame();
    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("ovl", 8'h00, 8'hFF, 8'h00, 1'b1, 3'd0);
    check("ovl.mask", 32'(collide_mask), 32'h5);
    pix(10'd100, 10'd50, 1'b1, pk(12'h0, 12'hF00, 12'h0, 12'h0), 12'h123);
    check("mask.hold", 32'(collide_mask), 32'h5);
    frame();
    check("mask.clr", 32'(collide_mask), 32'h0);

    pix(10'd200, 10'd200, 1'b1, pk(12'h000, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("key", 8'h00, 8'h00, 8'hFF, 1'b1, 3'd2);
    check("key.mask", 32'(collide_mask), 32'h0);

    cfg(3'd0, 10'd300, 10'd190, 10'd20, 1'b1, 1'b0);
    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("mv.old", 8'h00, 8'hFF, 8'h00, 1'b1, 3'd0);
    frame();
    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("mv.gone", 8'h00, 8'h00, 8'hFF, 1'b1, 3'd2);
    pix(10'd305, 10'd195, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("mv.new", 8'h00, 8'hFF, 8'h00, 1'b1, 3'd0);

    cfg(3'd0, 10'd190, 10'd190, 10'd20, 1'b1, 1'b1);
    pix(10'd305, 10'd195, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("co.still", 8'h00, 8'hFF, 8'h00, 1'b1, 3'd0);
    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("co.l2", 8'h00, 8'h00, 8'hFF, 1'b1, 3'd2);
    frame();
    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("co.moved", 8'h00, 8'hFF, 8'h00, 1'b1, 3'd0);
    frame();

    cfg(3'd7, 10'd0, 10'd0, 10'd1000, 1'b1, 1'b0);
    frame();
    pix(10'd0, 10'd0, 1'b1, pk(12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F), 12'h123);
    expect_px("bad.layer", 8'h11, 8'h22, 8'h33, 1'b0, 3'd0);

    cfg(3'd3, 10'd1000, 10'd0, 10'd40, 1'b1, 1'b0);
    frame();
    pix(10'd5, 10'd10, 1'b1, pk(12'h0, 12'h0, 12'h0, 12'hFFF), 12'h123);
    expect_px("wrap.hit", 8'hFF, 8'hFF, 8'hFF, 1'b1, 3'd3);
    pix(10'd999, 10'd10, 1'b1, pk(12'h0, 12'h0, 12'h0, 12'hFFF), 12'h123);
    expect_px("wrap.miss", 8'h11, 8'h22, 8'h33, 1'b0, 3'd3);

    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    check("pre.rst.mask", 32'(collide_mask), 32'h5);
    Reset_h = 1'b1;
    tick();
    Reset_h = 1'b0;
    expect_px("midrst", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    check("midrst.mask", 32'(collide_mask), 32'h0);
    pix(10'd200, 10'd200, 1'b1, pk(12'h0F0, 12'h0, 12'h00F, 12'h0), 12'h123);
    expect_px("midrst.dis", 8'h11, 8'h22, 8'h33, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
